// File: rtl/cmp_pkg.sv
// cmp_pkg: shared FSM state encoding and result codes for the serial
// magnitude comparator.
//   state_t    : IDLE / RUN
//   LT, EQ, GT : one-hot result codes ordered {lt, eq, gt}
//   NONE       : all-zero result, used while no compare has finished yet
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] LT   = 3'b100;
  localparam logic [2:0] EQ   = 3'b010;
  localparam logic [2:0] GT   = 3'b001;
  localparam logic [2:0] NONE = 3'b000;

endpackage

// File: rtl/cmp_digit.sv
// cmp_digit: combinational unsigned compare of one DIGIT-bit slice.
//   a, b : DIGIT-bit operands
//   lt   : a < b
//   gt   : a > b
//   Equality is implied when neither lt nor gt is set.
module cmp_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/cmp_serial.sv
// cmp_serial: MSB-first serial comparator, DIGIT bits per cycle with early
// termination on the first differing digit.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request a compare (accepted only while busy=0)
//   signed_mode   : 1 = two's complement, 0 = unsigned (sampled with start)
//   a, b          : WIDTH-bit operands (sampled with start)
//   busy          : compare in progress
//   done          : one-cycle pulse, lt/eq/gt updated in the same cycle
//   lt, eq, gt    : registered result, held between compares
// WIDTH must be a multiple of DIGIT.
module cmp_serial
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int D  = WIDTH / DIGIT;
  localparam int KW = $clog2(D + 1);
  localparam logic [KW-1:0] K_LAST = KW'(D);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [KW-1:0]    r_k;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_res;

  logic [WIDTH-1:0] w_a_lat;
  logic [WIDTH-1:0] w_b_lat;
  logic             w_lt;
  logic             w_gt;

  // Flipping both sign bits maps two's-complement order onto unsigned order,
  // so the datapath below never needs to know the mode.
  assign w_a_lat = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
  assign w_b_lat = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};

  // The current digit always sits at the top of the shifted registers.
  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (r_a[WIDTH-1 -: DIGIT]),
    .b  (r_b[WIDTH-1 -: DIGIT]),
    .lt (w_lt),
    .gt (w_gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= NONE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= w_a_lat;
            r_b     <= w_b_lat;
            r_k     <= K_ONE;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_lt || w_gt) begin
            r_res   <= w_lt ? LT : GT;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_k == K_LAST) begin
            r_res   <= EQ;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_a <= r_a << DIGIT;
            r_b <= r_b << DIGIT;
            r_k <= r_k + K_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign lt   = r_res[2];
  assign eq   = r_res[1];
  assign gt   = r_res[0];

endmodule

// File: tb/tb_cmp_serial.sv
module tb_cmp_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 8: WIDTH=8 DIGIT=1; instance 16: WIDTH=16 DIGIT=4
  logic        s8 = 0, sm8 = 0, busy8, done8, lt8, eq8, gt8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        s16 = 0, sm16 = 0, busy16, done16, lt16, eq16, gt16;
  logic [15:0] a16 = 0, b16 = 0;

  cmp_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .lt(lt8), .eq(eq8), .gt(gt8));

  cmp_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .signed_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .lt(lt16), .eq(eq16), .gt(gt16));

  int errs = 0;
  int checks = 0;

  localparam logic [2:0] R_LT = 3'b100, R_EQ = 3'b010, R_GT = 3'b001, R_0 = 3'b000;

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    int          lat;
    logic [2:0]  res;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] res_of(input int w);
    return (w == 8) ? {lt8, eq8, gt8} : {lt16, eq16, gt16};
  endfunction

  function automatic logic done_of(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  task automatic set_in(input int w, input logic st, input logic [15:0] ta,
                        input logic [15:0] tb, input logic sm);
    if (w == 8) begin s8 = st; a8 = ta[7:0]; b8 = tb[7:0]; sm8 = sm; end
    else        begin s16 = st; a16 = ta; b16 = tb; sm16 = sm; end
  endtask

  // Issue one compare, optionally spraying start pulses and operand noise
  // while busy, and measure edges from E0 to done.
  task automatic do_cmp(input string name, input int w, input logic [15:0] ta,
                        input logic [15:0] tb, input logic sm, input int exp_lat,
                        input logic [2:0] exp_res, input bit noise);
    int lat;
    lat = -1;
    @(negedge clk);
    set_in(w, 1'b1, ta, tb, sm);
    @(posedge clk); #1;  // E0
    set_in(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    chk({name, " busy"}, int'(busy_of(w)), 1);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done_of(w)) begin lat = n; break; end
      if (noise) set_in(w, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom));
    end
    set_in(w, 1'b0, 16'h0, 16'h0, 1'b0);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " result"}, int'(res_of(w)), int'(exp_res));
    chk({name, " busy@done"}, int'(busy_of(w)), 0);
    @(posedge clk); #1;
    chk({name, " single done"}, int'(done_of(w)), 0);
    chk({name, " result held"}, int'(res_of(w)), int'(exp_res));
    chk({name, " idle after"}, int'(busy_of(w)), 0);
  endtask

  initial begin
    int lat;
    vt[0]  = '{8,  16'h00A5, 16'h00A5, 1'b0, 8, R_EQ};
    vt[1]  = '{8,  16'h0080, 16'h007F, 1'b0, 1, R_GT};
    vt[2]  = '{8,  16'h0080, 16'h007F, 1'b1, 1, R_LT};
    vt[3]  = '{8,  16'h0040, 16'h0020, 1'b0, 2, R_GT};
    vt[4]  = '{8,  16'h00FF, 16'h0001, 1'b1, 1, R_LT};
    vt[5]  = '{8,  16'h00FF, 16'h00FE, 1'b1, 8, R_GT};
    vt[6]  = '{8,  16'h0081, 16'h0080, 1'b1, 8, R_GT};
    vt[7]  = '{8,  16'h0080, 16'h0080, 1'b1, 8, R_EQ};
    vt[8]  = '{16, 16'h1234, 16'h1243, 1'b0, 3, R_LT};
    vt[9]  = '{16, 16'h8000, 16'h7FFF, 1'b1, 1, R_LT};
    vt[10] = '{16, 16'hABCD, 16'hABCD, 1'b1, 4, R_EQ};
    vt[11] = '{16, 16'h0005, 16'h0003, 1'b0, 4, R_GT};

    // Reset state
    #12;
    chk("reset busy8", int'(busy8), 0);
    chk("reset done8", int'(done8), 0);
    chk("reset res8", int'({lt8, eq8, gt8}), 0);
    chk("reset res16", int'({lt16, eq16, gt16}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First start right after reset release
    do_cmp("first", 8, 16'h00A5, 16'h00A5, 1'b0, 8, R_EQ, 1'b0);

    for (int i = 0; i < 12; i++)
      do_cmp($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].b, vt[i].sm,
             vt[i].lat, vt[i].res, 1'b0);

    // Start pulses and operand changes during busy must be ignored
    do_cmp("noise", 8, 16'h0012, 16'h0013, 1'b0, 8, R_LT, 1'b1);

    // Back-to-back: second start issued in the done cycle
    @(negedge clk);
    set_in(16, 1'b1, 16'h1234, 16'h1243, 1'b0);
    @(posedge clk); #1;
    set_in(16, 1'b0, 16'h0, 16'h0, 1'b0);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done16) begin lat = n; break; end
    end
    chk("b2b first latency", lat, 3);
    chk("b2b first result", int'({lt16, eq16, gt16}), int'(R_LT));
    set_in(16, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    @(posedge clk); #1;
    set_in(16, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("b2b accepted", int'(busy16), 1);
    @(posedge clk); #1;
    chk("b2b second done", int'(done16), 1);
    chk("b2b second result", int'({lt16, eq16, gt16}), int'(R_GT));

    // Reset mid-compare aborts with no done
    @(negedge clk);
    set_in(8, 1'b1, 16'h0001, 16'h0001, 1'b0);
    @(posedge clk); #1;
    set_in(8, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int n = 0; n < 3; n++) begin @(posedge clk); #1; end
    chk("abort still busy", int'(busy8), 1);
    rst = 1'b1;
    #1;
    chk("abort busy", int'(busy8), 0);
    chk("abort done", int'(done8), 0);
    chk("abort res", int'({lt8, eq8, gt8}), int'(R_0));
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (done8) lat++;
    end
    chk("abort no done", lat, 0);
    do_cmp("after abort", 8, 16'h0001, 16'h0001, 1'b0, 8, R_EQ, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cmp_serial.md
CMP_SERIAL -- requirements
Module: cmp_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, >= 2.
REQ-002 SHALL have parameter DIGIT, default 1: bits compared per cycle; WIDTH mod DIGIT = 0 is required. D = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: request a compare; sampled only when busy=0.
REQ-006 SHALL have port signed_mode, input, 1: 1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-007 SHALL have port a, input, WIDTH: first operand; sampled with start.
REQ-008 SHALL have port b, input, WIDTH: second operand; sampled with start.
REQ-009 SHALL have port busy, output, 1: compare in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse; result is valid and updated in this cycle.
REQ-011 SHALL have ports lt, eq, gt, output, 1 each: a<b, a==b, a>b.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; the reset state is IDLE.
REQ-013 In IDLE, start=1 at edge E0 SHALL latch a, b and signed_mode, clear digit index k to 1, and enter RUN with busy=1.
REQ-014 When signed_mode=1, the MSB of both latched operands SHALL be inverted at latch time; all later compare logic is unsigned.
REQ-015 At each edge Ek in RUN, SHALL compare digit k (counting from the MSB; digit 1 = bits WIDTH-1..WIDTH-DIGIT).
REQ-016 If digit k differs, at Ek SHALL set lt/gt per that digit, set eq=0, pulse done=1, drop busy, and return to IDLE (early termination).
REQ-017 If digit k is equal and k=D, at ED SHALL set eq=1, lt=gt=0, pulse done=1, drop busy, and return to IDLE.
REQ-018 If digit k is equal and k<D, SHALL increment k and remain in RUN.
REQ-019 Latency SHALL be k cycles from E0 to done, where k is the first differing digit, or D if none; minimum 1, maximum D.
REQ-020 start while busy=1 SHALL be ignored; operands and mode changes during RUN SHALL have no effect.
REQ-021 start in the done cycle (busy=0) SHALL be accepted; back-to-back compares SHALL be supported with no idle cycle.
REQ-022 lt/eq/gt SHALL hold their value between done pulses and be one-hot after the first completion.
REQ-023 done SHALL never be high for two consecutive cycles from a single compare.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, busy=0, done=0, lt=eq=gt=0, k=0 and clear the operand registers, including mid-operation; an aborted compare SHALL produce no done.
REQ-025 The first start SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-026 A shared package cmp_pkg SHALL hold the FSM state encoding (IDLE, RUN) and the result-code constants (LT, EQ, GT).
REQ-027 Sub-module cmp_digit SHALL be combinational, parameterised by DIGIT, take two DIGIT-bit inputs and output lt and gt; cmp_serial SHALL instantiate it once.
REQ-028 Digit selection SHALL be implemented by a left shift of the operand registers by DIGIT per RUN cycle, not by a variable index mux.

Verification
REQ-029 WIDTH=8, DIGIT=1, unsigned, a=0xA5, b=0xA5 -> done 8 cycles after E0, eq=1, lt=gt=0.
REQ-030 WIDTH=8, DIGIT=1, a=0x80, b=0x7F -> unsigned: gt=1 with done 1 cycle after E0; signed: lt=1 with done 1 cycle after E0.
REQ-031 WIDTH=8, DIGIT=1, unsigned, a=0x12, b=0x13 -> lt=1 with done 8 cycles after E0; start pulses during busy produce no extra done, and the result is unchanged.
REQ-032 WIDTH=16, DIGIT=4, unsigned, a=0x1234, b=0x1243 -> lt=1 with done 3 cycles after E0; a second start in the done cycle with a=0xFFFF, b=0x0000 -> gt=1 one cycle later.
REQ-033 WIDTH=8, DIGIT=1: start a=0x01, b=0x01, assert rst at cycle 4 -> busy=0 and lt=eq=gt=0 immediately, no done pulse; the next start completes normally.
